// File: rtl/byte_packer_pkg.sv
// byte_packer_pkg: shared definitions for the byte packer.
//   DEF_DW / DEF_BYTES : default byte width and bytes per output word
//   CNT_W              : width of the fill counter for the default word size
//   fill_state_t       : accumulator fill state (EMPTY, FILL)
//   keep_mask()        : lane-keep mask with lanes 0..n set
// Optional feature macro used by the packer files: BYTE_PACKER_PARITY_EN.
package byte_packer_pkg;

    localparam int DEF_DW    = 8;
    localparam int DEF_BYTES = 4;
    localparam int CNT_W     = $clog2(DEF_BYTES);

    typedef enum logic {
        EMPTY = 1'b0,
        FILL  = 1'b1
    } fill_state_t;

    // Returns a mask with bits 0..n set. The result is wide enough for any
    // sensible word size; callers size-cast it down to their lane count.
    // For n == 63 the shift wraps to zero and the subtraction yields all ones.
    function automatic logic [63:0] keep_mask(input int unsigned n);
        return (64'd2 << n) - 64'd1;
    endfunction

endpackage

// File: rtl/byte_packer_oreg.sv
// byte_packer_oreg: single-entry output slot for the byte packer.
//   clk, rst           : clock, asynchronous active-high reset
//   load               : capture ld_* into the slot (slot free or draining)
//   ld_data/keep/last  : word presented by the accumulator
//   out_ready          : downstream accepts the slot contents
//   out_data/keep/last : registered word, held stable while stalled
//   out_valid          : slot occupied
//   out_par            : per-lane even parity (only with BYTE_PACKER_PARITY_EN)
module byte_packer_oreg #(
    parameter int DW    = 8,
    parameter int BYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DW*BYTES-1:0]   ld_data,
    input  logic [BYTES-1:0]      ld_keep,
    input  logic                  ld_last,
    input  logic                  out_ready,
    output logic [DW*BYTES-1:0]   out_data,
    output logic [BYTES-1:0]      out_keep,
    output logic                  out_last,
`ifdef BYTE_PACKER_PARITY_EN
    output logic [BYTES-1:0]      out_par,
`endif
    output logic                  out_valid
);

`ifdef BYTE_PACKER_PARITY_EN
    logic [BYTES-1:0] ld_par;

    // Parity is computed on the incoming word so it is registered in the
    // same edge as the data; dead lanes are forced to 0.
    always_comb begin
        ld_par = '0;
        for (int k = 0; k < BYTES; k++)
            ld_par[k] = (^ld_data[k*DW +: DW]) & ld_keep[k];
    end
`endif

    // Load wins over drain: a simultaneous drain and load replaces the word
    // and keeps out_valid high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
`ifdef BYTE_PACKER_PARITY_EN
            out_par   <= '0;
`endif
        end else if (load) begin
            out_data  <= ld_data;
            out_keep  <= ld_keep;
            out_last  <= ld_last;
            out_valid <= 1'b1;
`ifdef BYTE_PACKER_PARITY_EN
            out_par   <= ld_par;
`endif
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/byte_packer.sv
// byte_packer: packs a valid/ready byte stream into little-endian words.
//   clk, rst            : clock, asynchronous active-high reset
//   in_data/valid/last  : upstream byte, handshake and end-of-packet flag
//   in_ready            : byte accepted when in_valid && in_ready
//   out_data/keep/last  : packed word, lane-keep mask, end-of-packet flag
//   out_valid/out_ready : output slot handshake
//   out_par             : per-lane even parity (only with BYTE_PACKER_PARITY_EN)
// The accumulator holds up to BYTES-1 bytes; the completing byte bypasses it
// and goes straight into the output slot together with the stored lanes.
module byte_packer
    import byte_packer_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int BYTES = DEF_BYTES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DW-1:0]         in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [DW*BYTES-1:0]   out_data,
    output logic [BYTES-1:0]      out_keep,
    output logic                  out_last,
    output logic                  out_valid,
`ifdef BYTE_PACKER_PARITY_EN
    output logic [BYTES-1:0]      out_par,
`endif
    input  logic                  out_ready
);

    localparam int CW = $clog2(BYTES);

    logic [BYTES-1:0][DW-1:0] acc;
    logic [CW-1:0]            cnt;
    fill_state_t              state;

    logic                     accept;
    logic                     complete;
    logic [DW*BYTES-1:0]      word;
    logic [BYTES-1:0]         word_keep;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign complete = accept && (in_last || (cnt == CW'(BYTES - 1)));

    // Lanes below cnt come from the accumulator, lane cnt is the incoming
    // byte, lanes above are zero. Stale accumulator contents left over from
    // a previous word are never exposed because EMPTY blocks them.
    always_comb begin
        word = '0;
        for (int k = 0; k < BYTES; k++) begin
            if ((state == FILL) && (CW'(k) < cnt))
                word[k*DW +: DW] = acc[k];
            else if (CW'(k) == cnt)
                word[k*DW +: DW] = in_data;
        end
    end

    assign word_keep = BYTES'(keep_mask(32'(cnt)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
            cnt   <= '0;
            acc   <= '0;
        end else if (accept) begin
            if (complete) begin
                state <= EMPTY;
                cnt   <= '0;
            end else begin
                acc[cnt] <= in_data;
                cnt      <= cnt + CW'(1);
                state    <= FILL;
            end
        end
    end

    byte_packer_oreg #(
        .DW    (DW),
        .BYTES (BYTES)
    ) u_oreg (
        .clk       (clk),
        .rst       (rst),
        .load      (complete),
        .ld_data   (word),
        .ld_keep   (word_keep),
        .ld_last   (in_last),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_last  (out_last),
`ifdef BYTE_PACKER_PARITY_EN
        .out_par   (out_par),
`endif
        .out_valid (out_valid)
    );

endmodule

// File: tb/tb_byte_packer.sv
// tb_byte_packer: directed self-checking bench for byte_packer.
// Inputs change 1 time unit after the rising edge; outputs are checked at
// that same point, well away from the next active edge.
// Parity checks are included when BYTE_PACKER_PARITY_EN is defined.
module tb_byte_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;
`ifdef BYTE_PACKER_PARITY_EN
    logic [3:0]  out_par;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    byte_packer dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_last  (out_last),
        .out_valid (out_valid),
`ifdef BYTE_PACKER_PARITY_EN
        .out_par   (out_par),
`endif
        .out_ready (out_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one byte for exactly one cycle (caller knows it is accepted).
    task automatic send(input logic [7:0] d, input logic l);
        in_data  = d;
        in_valid = 1'b1;
        in_last  = l;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_word(input string tag, input logic [31:0] d,
                              input logic [3:0] k, input logic l);
        check({tag, " valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, " data"},  out_data, d);
        check({tag, " keep"},  {28'd0, out_keep}, {28'd0, k});
        check({tag, " last"},  {31'd0, out_last}, {31'd0, l});
    endtask

    initial begin
        rst       = 1'b1;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        check("rst valid", {31'd0, out_valid}, 32'd0);
        check("rst data",  out_data, 32'd0);
        check("rst keep",  {28'd0, out_keep}, 32'd0);
        check("rst last",  {31'd0, out_last}, 32'd0);
`ifdef BYTE_PACKER_PARITY_EN
        check("rst par",   {28'd0, out_par}, 32'd0);
`endif
        rst = 1'b0;
        #1;
        check("rst in_ready", {31'd0, in_ready}, 32'd1);
        step();

        // Full word back-to-back, one byte per cycle.
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        check("full pre valid", {31'd0, out_valid}, 32'd0);
        send(8'h44, 1'b0);
        check_word("full", 32'h44332211, 4'hF, 1'b0);
        step();
        check("full one cycle", {31'd0, out_valid}, 32'd0);

        // Two-byte packet flushed by last.
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b1);
        check_word("two", 32'h0000BBAA, 4'h3, 1'b1);
        step();

        // Last on the very first byte.
        send(8'h5A, 1'b1);
        check_word("one", 32'h0000005A, 4'h1, 1'b1);
        step();
        check("one drained", {31'd0, out_valid}, 32'd0);

        // Back-pressure: slot fills, in_ready falls, word holds.
        out_ready = 1'b0;
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        send(8'h04, 1'b0);
        check_word("bp first", 32'h04030201, 4'hF, 1'b0);
        in_data  = 8'h05;
        in_valid = 1'b1;
        #1;
        check("bp in_ready low", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp hold data", out_data, 32'h04030201);
            check("bp hold valid", {31'd0, in_ready, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        #1;
        check("bp in_ready high", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        check("bp drained", {31'd0, out_valid}, 32'd0);
        send(8'h06, 1'b0);
        send(8'h07, 1'b0);
        send(8'h08, 1'b0);
        check_word("bp second", 32'h08070605, 4'hF, 1'b0);

        // Drain and load on the same edge: valid stays high.
        send(8'h0D, 1'b1);
        check_word("swap", 32'h0000000D, 4'h1, 1'b1);
        step();

        // Reset mid-packet discards the partial word.
        send(8'hE1, 1'b0);
        send(8'hE2, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("mid rst valid", {31'd0, out_valid}, 32'd0);
        check("mid rst data",  out_data, 32'd0);
        step();
        rst = 1'b0;
        step();
        check("post rst idle", {31'd0, out_valid}, 32'd0);
        send(8'h31, 1'b0);
        send(8'h32, 1'b0);
        send(8'h33, 1'b0);
        send(8'h34, 1'b0);
        check_word("post rst", 32'h34333231, 4'hF, 1'b0);
        step();

        // Lane parity pattern 00,01,03,07.
        send(8'h00, 1'b0);
        send(8'h01, 1'b0);
        send(8'h03, 1'b0);
        send(8'h07, 1'b0);
        check_word("par word", 32'h07030100, 4'hF, 1'b0);
`ifdef BYTE_PACKER_PARITY_EN
        check("par full", {28'd0, out_par}, 32'hA);
`endif
        step();

        // Partial word parity: lanes 3,2 unused must read 0.
        send(8'h01, 1'b0);
        send(8'h03, 1'b1);
        check_word("par part", 32'h00000301, 4'h3, 1'b1);
`ifdef BYTE_PACKER_PARITY_EN
        check("par part bits", {28'd0, out_par}, 32'h1);
`endif
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
